// File: rtl/hall_conditioner.sv
// Hall front-end: synchronize, glitch-filter and legality-check the raw hall code,
// then derive direction, commutation period, stall and illegal-code faults.
module hall_conditioner #(
  parameter int FILT_CYCLES  = 16,
  parameter int PERIOD_W     = 24,
  parameter int STALL_CYCLES = 2000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          hall_in,
  output logic [2:0]          hall_out,
  output logic                hall_valid,
  output logic                edge_pulse,
  output logic                dir_obs,
  output logic                seq_error,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                stall,
  output logic                invalid_fault
);
  localparam int FW = $clog2(FILT_CYCLES);
  localparam logic [FW-1:0]       FILT_LAST  = FW'(FILT_CYCLES - 1);
  localparam logic [FW-1:0]       FILT_PRE   = FW'(FILT_CYCLES - 2);
  localparam logic [PERIOD_W-1:0] CNT_MAX    = '1;
  localparam logic [PERIOD_W-1:0] STALL_LAST = PERIOD_W'(STALL_CYCLES - 1);

  logic [2:0]          s1, hs, cand;
  logic [FW-1:0]       scnt;
  logic [PERIOD_W-1:0] cnt, cnt_inc;
  logic                has_ref;
  logic                accept, legal, edge_evt;

  function automatic logic [2:0] succ(input logic [2:0] c);
    case (c)
      3'b001:  succ = 3'b011;
      3'b011:  succ = 3'b010;
      3'b010:  succ = 3'b110;
      3'b110:  succ = 3'b100;
      3'b100:  succ = 3'b101;
      3'b101:  succ = 3'b001;
      default: succ = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] pred(input logic [2:0] c);
    case (c)
      3'b011:  pred = 3'b001;
      3'b010:  pred = 3'b011;
      3'b110:  pred = 3'b010;
      3'b100:  pred = 3'b110;
      3'b101:  pred = 3'b100;
      3'b001:  pred = 3'b101;
      default: pred = 3'b000;
    endcase
  endfunction

  // Acceptance fires on the cycle the stable count reaches its last value,
  // so a clean step lands FILT_CYCLES clocks after reaching hs.
  assign accept   = (hs == cand) && (scnt == FILT_PRE) && (cand != hall_out);
  assign legal    = (cand != 3'b000) && (cand != 3'b111);
  assign edge_evt = accept && legal;
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1            <= '0;
      hs            <= '0;
      cand          <= '0;
      scnt          <= '0;
      cnt           <= '0;
      has_ref       <= 1'b0;
      hall_out      <= '0;
      hall_valid    <= 1'b0;
      edge_pulse    <= 1'b0;
      dir_obs       <= 1'b1;
      seq_error     <= 1'b0;
      period        <= '0;
      period_valid  <= 1'b0;
      stall         <= 1'b0;
      invalid_fault <= 1'b0;
    end else begin
      s1           <= hall_in;
      hs           <= s1;
      edge_pulse   <= 1'b0;
      seq_error    <= 1'b0;
      period_valid <= 1'b0;

      if (hs != cand) begin
        cand <= hs;
        scnt <= '0;
      end else if (scnt != FILT_LAST) begin
        scnt <= scnt + 1'b1;
      end

      if (accept && !legal) invalid_fault <= 1'b1;

      if (edge_evt) begin
        hall_out      <= cand;
        hall_valid    <= 1'b1;
        invalid_fault <= 1'b0;
        edge_pulse    <= 1'b1;
        cnt           <= '0;
        stall         <= 1'b0;
        has_ref       <= 1'b1;
        if (hall_valid) begin
          if (cand == succ(hall_out))      dir_obs   <= 1'b1;
          else if (cand == pred(hall_out)) dir_obs   <= 1'b0;
          else                             seq_error <= 1'b1;
        end
        // has_ref is dropped by a stall, so the edge ending a stall has no reference
        if (has_ref) begin
          period       <= cnt_inc;
          period_valid <= 1'b1;
        end
      end else begin
        cnt <= cnt_inc;
        if (hall_valid && cnt == STALL_LAST) begin
          stall   <= 1'b1;
          has_ref <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_hall_conditioner.sv
// Directed bench for hall_conditioner: expected edges are queued as steps are driven
// and checked by a monitor when edge_pulse appears.
module tb_hall_conditioner;
  localparam int F  = 4;
  localparam int ST = 100;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    hall_in = 3'b000;
  logic [2:0]    hall_out;
  logic          hall_valid, edge_pulse, dir_obs, seq_error, period_valid, stall, invalid_fault;
  logic [PW-1:0] period;

  hall_conditioner #(.FILT_CYCLES(F), .PERIOD_W(PW), .STALL_CYCLES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .hall_in(hall_in), .hall_out(hall_out),
    .hall_valid(hall_valid), .edge_pulse(edge_pulse), .dir_obs(dir_obs),
    .seq_error(seq_error), .period(period), .period_valid(period_valid),
    .stall(stall), .invalid_fault(invalid_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] code;
    logic       dir;
    logic       seq;
    logic       pv;
    logic [7:0] per;
    int         ecyc;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;

  // model state
  logic [2:0] m_code  = 3'b000;
  logic       m_valid = 1'b0;
  logic       m_dir   = 1'b1;
  logic [7:0] m_per   = 8'd0;
  int         m_last  = 0;
  logic [2:0] fwd [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pos(input logic [2:0] c);
    pos = -1;
    for (int i = 0; i < 6; i++) if (fwd[i] == c) pos = i;
  endfunction

  // Drive a code and queue the edge it should produce, then hold for some cycles.
  task automatic drive(input logic [2:0] c, input int hold);
    exp_t e;
    int   gap, pp, pc;
    hall_in = c;
    if (c != 3'b000 && c != 3'b111 && c != m_code) begin
      e.code = c;
      e.ecyc = cyc + 6;
      e.seq  = 1'b0;
      e.pv   = 1'b0;
      e.per  = m_per;
      if (m_valid) begin
        gap = e.ecyc - m_last;
        pp  = pos(m_code);
        pc  = pos(c);
        if (pc == (pp + 1) % 6)      m_dir = 1'b1;
        else if (pp == (pc + 1) % 6) m_dir = 1'b0;
        else                         e.seq = 1'b1;
        if (gap <= ST) begin
          e.pv  = 1'b1;
          m_per = 8'(gap);
          e.per = m_per;
        end
      end
      e.dir   = m_dir;
      m_last  = e.ecyc;
      m_code  = c;
      m_valid = 1'b1;
      q.push_back(e);
    end
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic glitch(input logic [2:0] g, input logic [2:0] back);
    hall_in = g;
    repeat (3) @(posedge clk);
    #1;
    hall_in = back;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hall_out"}, 32'(hall_out), 32'h0);
    chk({tag, "_hall_valid"}, 32'(hall_valid), 32'h0);
    chk({tag, "_edge_pulse"}, 32'(edge_pulse), 32'h0);
    chk({tag, "_dir_obs"}, 32'(dir_obs), 32'h1);
    chk({tag, "_seq_error"}, 32'(seq_error), 32'h0);
    chk({tag, "_period"}, 32'(period), 32'h0);
    chk({tag, "_period_valid"}, 32'(period_valid), 32'h0);
    chk({tag, "_stall"}, 32'(stall), 32'h0);
    chk({tag, "_invalid_fault"}, 32'(invalid_fault), 32'h0);
  endtask

  always @(negedge clk) begin
    if (rst_n && edge_pulse) begin
      if (q.size() == 0) begin
        chk("unexpected_edge", 32'(hall_out), 32'h0 ^ 32'(hall_out) ^ 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("edge_code", 32'(hall_out), 32'(e.code));
        chk("edge_cycle", 32'(cyc), 32'(e.ecyc));
        chk("edge_dir", 32'(dir_obs), 32'(e.dir));
        chk("edge_seq", 32'(seq_error), 32'(e.seq));
        chk("edge_pv", 32'(period_valid), 32'(e.pv));
        chk("edge_period", 32'(period), 32'(e.per));
      end
    end
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // first code: latency of FILT_CYCLES+2 clocks
    drive(3'b001, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("lat_before", 32'(hall_out), 32'h0);
    @(posedge clk);
    #1;
    chk("lat_hall_out", 32'(hall_out), 32'h1);
    chk("lat_valid", 32'(hall_valid), 32'h1);
    chk("lat_edge", 32'(edge_pulse), 32'h1);
    repeat (14) @(posedge clk);
    #1;

    // forward steps, then a reverse step
    drive(3'b011, 20);
    drive(3'b010, 20);
    drive(3'b011, 20);
    chk("rev_dir", 32'(dir_obs), 32'h0);

    // short glitches are rejected
    glitch(3'b111, 3'b011);
    glitch(3'b010, 3'b011);
    chk("glitch_hold", 32'(hall_out), 32'h3);

    // illegal code held
    drive(3'b111, 10);
    chk("inv_fault", 32'(invalid_fault), 32'h1);
    chk("inv_hold", 32'(hall_out), 32'h3);
    drive(3'b010, 20);
    chk("inv_clear", 32'(invalid_fault), 32'h0);

    // reverse twice, then a skip 001->010
    drive(3'b011, 20);
    drive(3'b001, 20);
    drive(3'b010, 50);
    chk("skip_dir_kept", 32'(dir_obs), 32'h0);
    chk("stall_early", 32'(stall), 32'h0);
    repeat (70) @(posedge clk);
    #1;
    chk("stall_set", 32'(stall), 32'h1);

    // stall-ending edge has no period; the next one does
    drive(3'b110, 20);
    chk("stall_clear", 32'(stall), 32'h0);
    drive(3'b100, 30);
    drive(3'b101, 300);
    chk("slow_stall", 32'(stall), 32'h1);
    drive(3'b001, 300);
    chk("slow_period_kept", 32'(period), 32'(m_per));

    // asynchronous reset mid-sequence
    hall_in = 3'b011;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    #1;
    rst_n   = 1'b1;
    m_code  = 3'b000;
    m_valid = 1'b0;
    m_dir   = 1'b1;
    m_per   = 8'd0;
    drive(3'b011, 20);
    chk("post_rst_out", 32'(hall_out), 32'h3);

    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
